sha256_compress: RTL and testbench

Iterative SHA-256 compression engine: one round per clock, 64 rounds per 512-bit block. Sits directly upstream of the per-word chaining registers (H0..H7). The final working variable e of each block is the `d` operand of the H4 register, and likewise for the other words. It accepts a chaining value and message block under a start/busy handshake, and reports the final working state with a one-cycle done pulse tagged with the block index.

---
 rtl/sha256_compress_pkg.sv | 63 ++++++
 rtl/sha256_compress_if.sv | 16 +
 rtl/sha256_msg_sched.sv | 36 +++
 rtl/sha256_compress.sv | 115 +++++++++++
 tb/tb_sha256_compress.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/sha256_compress_pkg.sv
// sha256_pkg: shared word type, FSM state type, SHA-256 round constants,
// initial hash value and the bitwise round/schedule functions.
package sha256_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam word_t K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   // H0 in the top word, H7 in the bottom word.
   localparam logic [255:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic word_t rotr(input word_t x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic word_t bsig0(input word_t x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic word_t bsig1(input word_t x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic word_t ssig0(input word_t x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic word_t ssig1(input word_t x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

   function automatic word_t ch(input word_t e, input word_t f, input word_t g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic word_t maj(input word_t a, input word_t b, input word_t c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   // Eight independent 32-bit additions; carries never cross word boundaries.
   function automatic logic [255:0] add_words(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      r = '0;
      for (int i = 0; i < 8; i++)
         r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

endpackage

// File: rtl/sha256_compress_if.sv
// Start/busy/done handshake bundle between a block source and the compressor.
interface sha256_compress_if;
   logic          start;
   logic [1:0]    block_in;
   logic [255:0]  h_in;
   logic [511:0]  m_in;
   logic          busy;
   logic          done;
   logic [1:0]    block_out;
   logic [255:0]  state_out;

   modport master (output start, block_in, h_in, m_in,
                   input  busy, done, block_out, state_out);
   modport slave  (input  start, block_in, h_in, m_in,
                   output busy, done, block_out, state_out);
endinterface

// File: rtl/sha256_msg_sched.sv
// Message schedule: 16-word shift register. r_w[0] is always W[t] of the
// current round; each advance drops it and appends W[t+16].
module sha256_msg_sched
   import sha256_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_load,
   input  logic          i_adv,
   input  logic [511:0]  i_m,
   output word_t         o_wt
);

   word_t r_w [16];
   word_t w_new;

   // W[t+16] from the words currently at offsets 14, 9, 1 and 0.
   always_comb begin
      w_new = ssig1(r_w[14]) + r_w[9] + ssig0(r_w[1]) + r_w[0];
   end

   // Load the block on accept, shift one word per round.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) r_w[i] <= '0;
      end else if (i_load) begin
         for (int i = 0; i < 16; i++) r_w[i] <= i_m[511 - 32*i -: 32];
      end else if (i_adv) begin
         for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
         r_w[15] <= w_new;
      end
   end

   assign o_wt = r_w[0];

endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: iterative SHA-256 compression, one round per clock.
// Optional build macro SHA256_FEEDFORWARD_EN: when defined, state_out carries
// the final working state plus the captured chaining value (finished hash);
// otherwise the raw final a..h is reported.
//
//   state  | meaning
//   S_IDLE | waiting for start; outputs hold last result
//   S_RUN  | one round per edge, t = 0..ROUNDS-1
module sha256_compress
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64
)(
   input  logic              clk,
   input  logic              rst,
   sha256_compress_if.slave  bus
);

   localparam logic [5:0] LAST = 6'(ROUNDS - 1);

   state_t        r_state;
   logic [5:0]    r_t;
   word_t         r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h;
   logic [1:0]    r_blk;
   logic          r_busy;
   logic          r_done;
   logic [1:0]    r_blk_out;
   logic [255:0]  r_out;
`ifdef SHA256_FEEDFORWARD_EN
   // Chaining value is only needed when the feed-forward add happens here.
   logic [255:0]  r_hin;
`endif

   logic          w_load;
   logic          w_adv;
   word_t         w_wt;
   word_t         w_t1;
   word_t         w_t2;
   logic [255:0]  w_final;
   logic [255:0]  w_out;

   assign w_load = (r_state == S_IDLE) && bus.start;
   assign w_adv  = (r_state == S_RUN);

   sha256_msg_sched u_sched (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_load),
      .i_adv  (w_adv),
      .i_m    (bus.m_in),
      .o_wt   (w_wt)
   );

   // Round function and the state that the last round would produce.
   always_comb begin
      w_t1    = r_h + bsig1(r_e) + ch(r_e, r_f, r_g) + K[r_t] + w_wt;
      w_t2    = bsig0(r_a) + maj(r_a, r_b, r_c);
      w_final = {w_t1 + w_t2, r_a, r_b, r_c, r_d + w_t1, r_e, r_f, r_g};
`ifdef SHA256_FEEDFORWARD_EN
      w_out   = add_words(w_final, r_hin);
`else
      w_out   = w_final;
`endif
   end

   // Control FSM, round counter, working registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_t       <= '0;
         {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= '0;
         r_blk     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_blk_out <= '0;
         r_out     <= '0;
`ifdef SHA256_FEEDFORWARD_EN
         r_hin     <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= bus.h_in;
                  r_blk   <= bus.block_in;
                  r_t     <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_RUN;
`ifdef SHA256_FEEDFORWARD_EN
                  r_hin   <= bus.h_in;
`endif
               end
            end
            S_RUN: begin
               {r_a, r_b, r_c, r_d, r_e, r_f, r_g, r_h} <= w_final;
               r_t <= r_t + 6'd1;
               if (r_t == LAST) begin
                  r_out     <= w_out;
                  r_blk_out <= r_blk;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.block_out = r_blk_out;
   assign bus.state_out = r_out;

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known-answer digests, handshake
// timing, ignored start, mid-block reset, random blocks against a software
// model, and a 16-round instance.
module tb_sha256_compress;
   import sha256_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   sha256_compress_if bus ();
   sha256_compress_if bus16 ();

   sha256_compress #(.ROUNDS(64)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   sha256_compress #(.ROUNDS(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

   localparam logic [511:0] M_ABC = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] M_TWO1 = {
      32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
      32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
      32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
      32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] M_TWO2 = {480'h0, 32'h000001c0};
   localparam logic [255:0] D_ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] D_TWO =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
      return r;
   endfunction

   // Reference compression: full schedule expanded up front, then n rounds.
   function automatic logic [255:0] model(input logic [255:0] h, input logic [511:0] m, input int n);
      logic [31:0] w [64];
      logic [31:0] v [8];
      logic [31:0] t1, t2, s0, s1;
      logic [255:0] s;
      for (int i = 0; i < 16; i++) w[i] = m[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++) begin
         s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
         s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
         w[i] = s1 + w[i-7] + s0 + w[i-16];
      end
      for (int i = 0; i < 8; i++) v[i] = h[255 - 32*i -: 32];
      for (int t = 0; t < n; t++) begin
         t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
              + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
         t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
              + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
         for (int i = 7; i > 0; i--) v[i] = v[i-1];
         v[4] = v[4] + t1;
         v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) s[255 - 32*i -: 32] = v[i];
      return s;
   endfunction

   // Expected state_out for a given chaining input and raw final state.
   function automatic logic [255:0] exp_out(input logic [255:0] h, input logic [255:0] raw);
`ifdef SHA256_FEEDFORWARD_EN
      return add8(raw, h);
`else
      return raw;
`endif
   endfunction

   // Finished digest recovered from state_out.
   function automatic logic [255:0] digest(input logic [255:0] h, input logic [255:0] o);
`ifdef SHA256_FEEDFORWARD_EN
      return o;
`else
      return add8(o, h);
`endif
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
      return r;
   endfunction

   // Present a block and hold start for the accept edge; then scramble inputs.
   task automatic launch(input logic [255:0] h, input logic [511:0] m, input logic [1:0] tag);
      bus.h_in = h; bus.m_in = m; bus.block_in = tag; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.h_in = rnd512()[255:0];
      bus.m_in = rnd512();
      bus.block_in = 2'(~tag);
   endtask

   // Count edges until done is seen (bounded).
   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus.done && lat < 200);
   endtask

   initial begin
      int lat;
      int seen;
      logic [255:0] h1, hr, raw;
      logic [511:0] mr;
      logic [1:0] tg;

      bus.start = 1'b0; bus.block_in = '0; bus.h_in = '0; bus.m_in = '0;
      bus16.start = 1'b0; bus16.block_in = '0; bus16.h_in = '0; bus16.m_in = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      chk("rst_busy", 256'(bus.busy), 256'(0));
      chk("rst_done", 256'(bus.done), 256'(0));
      chk("rst_state", bus.state_out, 256'(0));
      chk("rst_blk", 256'(bus.block_out), 256'(0));

      // "abc" single block
      launch(IV, M_ABC, 2'd1);
      chk("abc_busy", 256'(bus.busy), 256'(1));
      wait_done(lat);
      chk("abc_latency", 256'(lat), 256'(64));
      chk("abc_digest", digest(IV, bus.state_out), D_ABC);
      chk("abc_blk", 256'(bus.block_out), 256'(1));
      @(posedge clk); #1;
      chk("abc_done_pulse", 256'(bus.done), 256'(0));
      chk("abc_hold", digest(IV, bus.state_out), D_ABC);

      // Two-block message, second block started in the done cycle of the first
      h1 = add8(model(IV, M_TWO1, 64), IV);
      launch(IV, M_TWO1, 2'd1);
      wait_done(lat);
      chk("two1_latency", 256'(lat), 256'(64));
      chk("two1_blk", 256'(bus.block_out), 256'(1));
      chk("two1_state", bus.state_out, exp_out(IV, model(IV, M_TWO1, 64)));
      launch(h1, M_TWO2, 2'd2);
      chk("b2b_busy", 256'(bus.busy), 256'(1));
      wait_done(lat);
      chk("two2_latency", 256'(lat), 256'(64));
      chk("two2_blk", 256'(bus.block_out), 256'(2));
      chk("two_digest", digest(h1, bus.state_out), D_TWO);

      // start during round 10 with a different block must be ignored
      @(posedge clk); #1;
      launch(IV, M_ABC, 2'd3);
      repeat (10) @(posedge clk);
      #1 bus.start = 1'b1; bus.m_in = rnd512(); bus.block_in = 2'd0;
      @(posedge clk); #1 bus.start = 1'b0;
      wait_done(lat);
      chk("ign_latency", 256'(lat + 11), 256'(64));
      chk("ign_digest", digest(IV, bus.state_out), D_ABC);
      chk("ign_blk", 256'(bus.block_out), 256'(3));
      @(posedge clk); #1;
      chk("ign_no_second_done", 256'(bus.done), 256'(0));

      // Random blocks back to back against the model
      for (int k = 0; k < 6; k++) begin
         hr = rnd512()[255:0];
         mr = rnd512();
         tg = 2'($urandom_range(0, 3));
         raw = model(hr, mr, 64);
         launch(hr, mr, tg);
         wait_done(lat);
         chk($sformatf("rnd%0d_latency", k), 256'(lat), 256'(64));
         chk($sformatf("rnd%0d_state", k), bus.state_out, exp_out(hr, raw));
         chk($sformatf("rnd%0d_blk", k), 256'(bus.block_out), 256'(tg));
      end

      // 16-round debug instance
      bus16.h_in = IV; bus16.m_in = M_ABC; bus16.block_in = 2'd2; bus16.start = 1'b1;
      @(posedge clk); #1 bus16.start = 1'b0; bus16.m_in = '0;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!bus16.done && lat < 200);
      chk("r16_latency", 256'(lat), 256'(16));
      chk("r16_state", bus16.state_out, exp_out(IV, model(IV, M_ABC, 16)));
      chk("r16_blk", 256'(bus16.block_out), 256'(2));

      // Reset mid-block: everything clears, no done afterwards
      @(posedge clk); #1;
      launch(IV, M_ABC, 2'd1);
      repeat (30) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      chk("mrst_busy", 256'(bus.busy), 256'(0));
      chk("mrst_done", 256'(bus.done), 256'(0));
      chk("mrst_state", bus.state_out, 256'(0));
      chk("mrst_blk", 256'(bus.block_out), 256'(0));
      seen = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (bus.done || bus.busy) seen++;
      end
      chk("mrst_no_done", 256'(seen), 256'(0));

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
